rob_commit_unit: RTL

- Reorder buffer and in-order commit engine. It is the writer side of the register rename interface.
- Hands out ROB ids to the Decoder and collects results from the CDB.
- Retires entries in program order: one register write-back per cycle to the register file, which clears a busy tag only when the tag matches.
- On committing a mispredicted branch it empties itself and issues a pipeline flush.

---
 rtl/rob_commit_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates ids to decode, captures CDB results, retires in order.
// Ports: ID_* alloc, CDB_* results, RF_commit_* write-back pulse, flush_* redirect.
module rob_commit_unit #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_ID_W  = 4,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 ID_alloc_valid,
  input  logic [REG_IDX_W-1:0] ID_rd,
  input  logic                 ID_is_branch,
  output logic [ROB_ID_W-1:0]  ID_ROB_id,
  output logic                 ROB_full,
  input  logic                 CDB_valid,
  input  logic [ROB_ID_W-1:0]  CDB_ROB_id,
  input  logic [DATA_W-1:0]    CDB_value,
  input  logic                 CDB_mispredict,
  input  logic [DATA_W-1:0]    CDB_target_pc,
  output logic                 RF_commit_valid,
  output logic [REG_IDX_W-1:0] RF_commit_rd,
  output logic [DATA_W-1:0]    RF_commit_value,
  output logic [ROB_ID_W-1:0]  RF_commit_ROB_id,
  output logic                 flush_valid,
  output logic [DATA_W-1:0]    flush_pc
);

  typedef enum logic [1:0] {
    EMPTY,
    ISSUED,
    READY
  } ent_st_t;

  localparam logic [ROB_ID_W:0] SIZE_C = (ROB_ID_W+1)'(ROB_SIZE);
  localparam logic [ROB_ID_W-1:0] ONE_ID = ROB_ID_W'(1);
  localparam logic [ROB_ID_W:0] ONE_CNT = (ROB_ID_W+1)'(1);

  ent_st_t              st     [ROB_SIZE];
  logic [REG_IDX_W-1:0] rd_q   [ROB_SIZE];
  logic                 br_q   [ROB_SIZE];
  logic [DATA_W-1:0]    val_q  [ROB_SIZE];
  logic                 misp_q [ROB_SIZE];
  logic [DATA_W-1:0]    tgt_q  [ROB_SIZE];

  logic [ROB_ID_W-1:0] head;
  logic [ROB_ID_W-1:0] tail;
  logic [ROB_ID_W:0]   count;

  logic full;
  logic alloc;
  logic commit;
  logic flush;
  logic cdb_wr;

  assign full      = (count == SIZE_C);
  assign ROB_full  = full;
  assign ID_ROB_id = tail;

  // Head readiness is sampled from current state, so a CDB hit on
  // head this cycle only allows commit on the following cycle.
  assign alloc  = rdy && ID_alloc_valid && !full;
  assign commit = rdy && (st[head] == READY);
  assign flush  = commit && br_q[head] && misp_q[head];
  assign cdb_wr = rdy && CDB_valid && (st[CDB_ROB_id] == ISSUED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) st[i] <= EMPTY;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      RF_commit_valid  <= 1'b0;
      RF_commit_rd     <= '0;
      RF_commit_value  <= '0;
      RF_commit_ROB_id <= '0;
      flush_valid      <= 1'b0;
      flush_pc         <= '0;
    end else begin
      RF_commit_valid <= commit && (rd_q[head] != '0);
      flush_valid     <= flush;
      if (commit) begin
        RF_commit_rd     <= rd_q[head];
        RF_commit_value  <= val_q[head];
        RF_commit_ROB_id <= head;
      end
      if (flush) flush_pc <= tgt_q[head];
      if (flush) begin
        // Mispredict: drop every younger entry, including any
        // allocation or CDB result arriving this same cycle.
        for (int i = 0; i < ROB_SIZE; i++) st[i] <= EMPTY;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit) begin
          st[head] <= EMPTY;
          head     <= head + ONE_ID;
        end
        if (alloc) begin
          st[tail] <= ISSUED;
          tail     <= tail + ONE_ID;
        end
        if (cdb_wr) st[CDB_ROB_id] <= READY;
        unique case (1'b1)
          alloc && !commit: count <= count + ONE_CNT;
          commit && !alloc: count <= count - ONE_CNT;
          default:          count <= count;
        endcase
      end
    end
  end

  // Payload carries no reset: it is only read once the entry state
  // says it was written.
  always_ff @(posedge clk) begin
    if (alloc) begin
      rd_q[tail] <= ID_rd;
      br_q[tail] <= ID_is_branch;
    end
    if (cdb_wr) begin
      val_q[CDB_ROB_id]  <= CDB_value;
      misp_q[CDB_ROB_id] <= CDB_mispredict;
      tgt_q[CDB_ROB_id]  <= CDB_target_pc;
    end
  end

endmodule
